seg7_hold_display: RTL and testbench
====================================

SEG7_HOLD_DISPLAY -- requirements
Module: seg7_hold_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, meaning: consecutive cycles the synchronized button must differ from its debounced level before that level updates; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 count  input  4  free-running value from the upstream 4-bit counter, synchronous to clk.
REQ-005 hold_btn  input  1  raw push-button, asynchronous to clk, active-high, may bounce.
REQ-006 seg  output  7  hex digit segments, active-high; seg[0]=a ... seg[6]=g.
REQ-007 dp  output  1  decimal point; wrap-parity indicator.
REQ-008 hold_led  output  1  1 = display frozen (HOLD mode).
REQ-009 wrap_pulse  output  1  one-cycle pulse per detected count wrap 0xF->0x0.

Function
REQ-010 hold_btn SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use; sync2 is the synchronized level s.
REQ-011 Debounce: debounced level db and an 8-bit counter cnt; s==db -> cnt<=0; s!=db and cnt==DEBOUNCE_CYCLES-1 -> db<=s, cnt<=0; otherwise cnt<=cnt+1.
REQ-012 Mode FSM, two states: LIVE (hold_led=0), HOLD (hold_led=1); a db 0->1 transition toggles state on the same edge db updates; db 1->0 has no effect.
REQ-013 Display register val_q (4 bits): in LIVE, each edge val_q<=count; in HOLD, val_q holds.
REQ-014 Edge where LIVE->HOLD occurs: val_q still loads count (last live sample). Edge where HOLD->LIVE occurs: val_q holds; loading resumes on the following edge.
REQ-015 seg SHALL be the combinational decode of val_q, as {g..a} hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-016 Latency: in LIVE, count present at edge N appears on seg after edge N (1 cycle).
REQ-017 prev_q SHALL register count every edge regardless of mode.
REQ-018 wrap_pulse is registered: wrap_pulse<=(prev_q==4'hF && count==4'h0); high exactly one cycle per wrap; other jumps (e.g. F->1, 0->0) produce no pulse.
REQ-019 dp toggles on each edge where wrap_pulse is being set to 1, in both modes; dp is wrap-count parity.
REQ-020 Wrap detection and dp SHALL NOT depend on hold_btn or mode.
REQ-021 Button stuck high: exactly one toggle; no further toggles until db returns to 0 and rises again.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no db change.

Reset
REQ-023 rst=1 at a posedge SHALL set: sync1=sync2=0, db=0, cnt=0, state LIVE, val_q=0, prev_q=0, wrap_pulse=0, dp=0; hence seg=3F, hold_led=0.
REQ-024 Reset takes priority over every other event, including mid-debounce, mid-HOLD, and a coincident wrap; prev_q=0 after reset so count==0 in the first post-reset cycle SHALL NOT produce a wrap.
REQ-025 All outputs are deterministic from the first edge with rst=1; no X propagation after reset.

Verification
REQ-026 Reset, then count=5 held -> seg=3F during reset, seg=6D one cycle after release; hold_led=0, dp=0, wrap_pulse=0.
REQ-027 Count ramps 0..F..0 in LIVE -> seg follows with 1-cycle lag; wrap_pulse=1 for exactly the cycle after count returns to 0; dp goes 0->1; second wrap -> dp back to 0.
REQ-028 hold_btn high with count=7 applied, held >= 2+DEBOUNCE_CYCLES cycles -> hold_led=1; seg frozen at the last value loaded on the toggle edge; count keeps ramping, wraps still pulse wrap_pulse and toggle dp.
REQ-029 hold_btn glitches (high 3 cycles, low 2, repeated, DEBOUNCE_CYCLES=8) -> no mode change; then clean press >= 10 cycles -> exactly one toggle; release and press again -> returns to LIVE, seg resumes one edge after the loaded edge per REQ-014.
REQ-030 rst asserted while in HOLD with cnt mid-count and count=F->0 coincident -> next cycle: hold_led=0, seg=3F, dp=0, wrap_pulse=0; no pulse in first post-reset cycle.

Source files
------------

// File: rtl/seg7_hold_display.sv
// Hex digit display fed by a free-running 4-bit counter.
// A debounced push-button toggles between LIVE (display follows the counter)
// and HOLD (display frozen). Counter wraps F->0 are detected independently of
// the mode: each one pulses wrap_pulse and toggles the decimal point.
module seg7_hold_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       hold_btn,
  output logic [6:0] seg,
  output logic       dp,
  output logic       hold_led,
  output logic       wrap_pulse
);

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } mode_e;

  // Terminal value of the debounce counter; the level flips when it is reached.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       db_q;
  logic       db_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  mode_e      state_q;
  mode_e      state_d;
  logic [3:0] val_q;
  logic [3:0] val_d;
  logic [3:0] prev_q;
  logic       wrap_q;
  logic       wrap_d;
  logic       dp_q;
  logic       dp_d;
  logic       db_rise;

  // Debounce: the synchronized level must disagree with db for
  // DEBOUNCE_CYCLES consecutive cycles before db follows it.
  always_comb begin
    db_d  = db_q;
    cnt_d = 8'd0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // A rising debounced level is detected on the same edge db updates.
  assign db_rise = db_d & ~db_q;

  // Mode FSM: each debounced press toggles LIVE/HOLD; releases are ignored.
  always_comb begin
    state_d = state_q;
    if (db_rise) begin
      state_d = (state_q == LIVE) ? HOLD : LIVE;
    end
  end

  // Display load and wrap detection. Loading is decided by the current mode,
  // so the LIVE->HOLD edge still captures count and the HOLD->LIVE edge does not.
  always_comb begin
    val_d  = (state_q == LIVE) ? count : val_q;
    wrap_d = (prev_q == 4'hF) && (count == 4'h0);
    dp_d   = dp_q ^ wrap_d;
  end

  // State registers; reset overrides everything, including a coincident wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= 8'd0;
      state_q <= LIVE;
      val_q   <= 4'h0;
      prev_q  <= 4'h0;
      wrap_q  <= 1'b0;
      dp_q    <= 1'b0;
    end else begin
      sync1_q <= hold_btn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      val_q   <= val_d;
      prev_q  <= count;
      wrap_q  <= wrap_d;
      dp_q    <= dp_d;
    end
  end

  // Hex to seven-segment decode, {g,f,e,d,c,b,a}, active-high.
  always_comb begin
    seg = 7'h00;
    case (val_q)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign dp         = dp_q;
  assign hold_led   = (state_q == HOLD);
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_seg7_hold_display.sv
// Directed bench for seg7_hold_display. The stimulus process pushes the
// expected outputs for each clock edge into a queue; a separate monitor pops
// one entry per cycle and compares it with the DUT outputs.
module tb_seg7_hold_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       hold_btn;
  logic [6:0] seg;
  logic       dp;
  logic       hold_led;
  logic       wrap_pulse;

  always #5 clk = ~clk;

  seg7_hold_display #(.DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .hold_btn   (hold_btn),
    .seg        (seg),
    .dp         (dp),
    .hold_led   (hold_led),
    .wrap_pulse (wrap_pulse)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       led;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected-state bookkeeping for the directed sequence.
  logic [3:0] ev    = 4'h0;
  logic [3:0] tprev = 4'h0;
  logic       edp   = 1'b0;
  logic       eled  = 1'b0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // One clock of stimulus. tog marks the edge on which the hand-counted
  // debounce (2 sync + 8 stable cycles = 10th pressed edge) toggles the mode.
  task automatic step(input logic [3:0] c, input logic b, input logic r, input logic tog);
    exp_t e;
    logic ewrap;
    count    = c;
    hold_btn = b;
    rst      = r;
    if (r) begin
      ev = 4'h0; edp = 1'b0; eled = 1'b0; ewrap = 1'b0; tprev = 4'h0;
    end else begin
      ewrap = (tprev == 4'hF) && (c == 4'h0);
      edp   = edp ^ ewrap;
      if (!eled) ev = c;
      if (tog) eled = ~eled;
      tprev = c;
    end
    e.seg  = hex7(ev);
    e.dp   = edp;
    e.led  = eled;
    e.wrap = ewrap;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // n steps with count ramping from c0; toggle expected on step tog_at (1-based).
  task automatic run(input logic [3:0] c0, input logic b, input int n, input int tog_at);
    for (int i = 1; i <= n; i++) begin
      step(c0 + 4'(i - 1), b, 1'b0, i == tog_at);
    end
  endtask

  // Monitor: one comparison per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({seg, dp, hold_led, wrap_pulse} !== e) begin
          n_bad++;
          $display("FAIL outputs #%0d: got seg=%h dp=%b led=%b wrap=%b, need seg=%h dp=%b led=%b wrap=%b",
                   n_cmp, seg, dp, hold_led, wrap_pulse, e.seg, e.dp, e.led, e.wrap);
        end else begin
          $display("chk #%0d seg=%h dp=%b led=%b wrap=%b ok", n_cmp, seg, dp, hold_led, wrap_pulse);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, need completion before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; count = 4'h5; hold_btn = 1'b0;

    // Reset with count=5, then release: 3F during reset, 6D afterwards.
    for (int i = 0; i < 3; i++) step(4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h5, 1'b0, 1'b0, 1'b0);

    // LIVE ramp through two wraps.
    run(4'h0, 1'b0, 34, 0);

    // Non-wrap jumps: F->1 and 0->0 must not pulse.
    step(4'hF, 1'b0, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);

    // Press with count=7: enters HOLD showing 7.
    for (int i = 1; i <= 12; i++) step(4'h7, 1'b1, 1'b0, i == 10);

    // Button stuck high while count ramps and wraps: no further toggle.
    run(4'h8, 1'b1, 40, 0);
    run(4'h0, 1'b0, 12, 0);

    // Second press returns to LIVE; loading resumes one edge later.
    run(4'h4, 1'b1, 12, 10);
    run(4'h0, 1'b0, 12, 0);

    // Glitches: high 3, low 2, repeated -- no mode change.
    for (int rep = 0; rep < 4; rep++) begin
      run(4'(rep * 5), 1'b1, 3, 0);
      run(4'(rep * 5 + 3), 1'b0, 2, 0);
    end

    // Clean press -> HOLD, release, press -> LIVE.
    run(4'h2, 1'b1, 12, 10);
    run(4'h0, 1'b0, 12, 0);
    run(4'h9, 1'b1, 12, 10);
    run(4'h5, 1'b0, 12, 0);

    // Make dp=1 before the reset scenario so its clearing is visible.
    if (!edp) begin
      step(4'hF, 1'b0, 1'b0, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b0);
    end

    // Enter HOLD, release, start a new debounce, then reset on a coincident F->0.
    run(4'h1, 1'b1, 12, 10);
    run(4'h0, 1'b0, 12, 0);
    run(4'h3, 1'b1, 5, 0);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    run(4'h1, 1'b0, 4, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
